// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: relation and FSM state
// encodings plus the per-bit decision helper.
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    REL_EQ = 2'b00,
    REL_LT = 2'b01,
    REL_GT = 2'b10
  } rel_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Relation implied by one bit pair; invert flips the sense for a sign bit.
  function automatic rel_t decide_bit(input logic a_bit, input logic b_bit,
                                      input logic invert);
    logic a_wins;
    if (a_bit == b_bit) return REL_EQ;
    a_wins = a_bit ^ invert;
    return a_wins ? REL_GT : REL_LT;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register presenting its MSB; shifts left with
// zero fill.
module piso_shift_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] par_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i)       data_d = par_i;
    else if (shift_i) data_d = {data_q[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign msb_o = data_q[WIDTH-1];

endmodule

// File: rtl/serial_magnitude_comparator.sv
// MSB-first bit-serial magnitude comparator, unsigned or two's-complement per
// operation. Optional macro EARLY_EXIT_EN finishes as soon as the relation is known.
module serial_magnitude_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  rel_t             rel_q, rel_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sm_q, sm_d;
  logic             lt_q, eq_q, gt_q;
  logic             load, shift, res_ld;
  logic             a_msb, b_msb;
  rel_t             bit_rel;

  piso_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .par_i   (a),
    .msb_o   (a_msb)
  );

  piso_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .par_i   (b),
    .msb_o   (b_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rel_q   <= REL_EQ;
      count_q <= '0;
      sm_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rel_q   <= rel_d;
      count_q <= count_d;
      sm_q    <= sm_d;
      if (res_ld) begin
        lt_q <= (rel_d == REL_LT);
        eq_q <= (rel_d == REL_EQ);
        gt_q <= (rel_d == REL_GT);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rel_d   = rel_q;
    count_d = count_q;
    sm_d    = sm_q;
    load    = 1'b0;
    shift   = 1'b0;
    res_ld  = 1'b0;
    // Only the very first bit of a signed operand is a sign bit.
    bit_rel = decide_bit(a_msb, b_msb, sm_q && (count_q == '0));
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          sm_d    = signed_mode;
          rel_d   = REL_EQ;
          count_d = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        shift   = 1'b1;
        count_d = count_q + CNT_W'(1);
        if (rel_q == REL_EQ) rel_d = bit_rel;
`ifdef EARLY_EXIT_EN
        if ((count_q == LAST_IDX) || (rel_q == REL_EQ && bit_rel != REL_EQ)) begin
          state_d = DONE;
          res_ld  = 1'b1;
        end
`else
        if (count_q == LAST_IDX) begin
          state_d = DONE;
          res_ld  = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  assign lt = lt_q;
  assign eq = eq_q;
  assign gt = gt_q;

endmodule

// File: doc/serial_magnitude_comparator.md
Name: serial_magnitude_comparator

Overview:
- Bit-serial magnitude comparator for two WIDTH-bit operands, processed MSB-first at one bit per clock.
- Supports unsigned and two's-complement signed compare, selected per operation.
- Uses a start/busy/done handshake and holds its registered result between operations.
- Sits beside the datapath as a low-area compare unit. It replaces the fixed 32-bit, op-strobed comparator with a self-sequencing, parametrised one.

Parameters:
WIDTH, 32, operand width in bits (>= 2)
CNT_W, $clog2(WIDTH), bit-index counter width (derived; not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with start
a  input  WIDTH  operand A; captured with start
b  input  WIDTH  operand B; captured with start
busy  output  1  operation in progress
done  output  1  single-cycle pulse, result valid
lt  output  1  A < B (registered, held)
eq  output  1  A == B (registered, held)
gt  output  1  A > B (registered, held)

Behaviour:
- Reset, asynchronous and immediate:
  - state=IDLE, busy=0, done=0, lt=eq=gt=0, rel=REL_EQ, count=0, shift registers cleared.
- States:
  - IDLE: busy=0. start=1 at the edge -> load a, b, signed_mode; rel=REL_EQ; count=0; go to RUN.
  - RUN: busy=1. Each edge:
    - Compare the MSB of both shift registers, then shift both left by 1 (zero fill). count increments.
    - If rel==REL_EQ and the bits differ:
      - A bit=1, B bit=0 -> REL_GT.
      - A bit=0, B bit=1 -> REL_LT.
      - For count==0 with signed_mode=1 only, the decision is inverted (sign bit).
    - Once rel leaves REL_EQ it is sticky.
    - At count==WIDTH-1, after processing -> DONE.
  - DONE: one cycle.
    - done=1, busy=0.
    - lt/eq/gt were loaded from the final rel at the RUN->DONE edge and are one-hot.
    - start=1 in DONE is accepted exactly as in IDLE (back-to-back).
    - Otherwise go to IDLE.
- Latency: start edge k -> busy high cycles k+1..k+WIDTH -> done high cycle k+WIDTH+1.
- Results:
  - lt/eq/gt hold their value until the next DONE. They are not cleared by start.
  - Before the first completed operation all three are 0.
- start while busy=1: ignored; operands are not re-captured.
- a/b/signed_mode changing during RUN: no effect.
- rst mid-operation: abort; all outputs return to reset values; no done pulse.
- rst released with start=1: start is sampled at the first edge after release.

Optional Feature:
Macro EARLY_EXIT_EN.
- Defined:
  - The first edge at which rel leaves REL_EQ goes directly to DONE.
  - Latency = (index of first differing bit from MSB)+2 cycles from the start edge.
  - Equal operands still take the full WIDTH+1 cycles.
- Undefined: fixed latency, WIDTH+1 cycles always; the remaining bits are shifted but do not change rel.

Decomposition:
- Package serial_cmp_pkg:
  - rel_t (REL_EQ=2'b00, REL_LT=2'b01, REL_GT=2'b10).
  - state_t (IDLE, RUN, DONE).
- One natural sub-module, piso_shift_reg:
  - Parametrised WIDTH; ports load, shift, parallel in, MSB out.
  - Instantiated twice, for A and B.

Test Plan:
- Unsigned, WIDTH=32: a=0x0000_0005, b=0x0000_0003, signed_mode=0 -> done at start+33; gt=1, lt=0, eq=0; busy high exactly 32 cycles.
- Signed: a=0xFFFF_FFFF (-1), b=0x0000_0001, signed_mode=1 -> lt=1. Same operands with signed_mode=0 -> gt=1.
- Equal: a=b=0xA5A5_A5A5 -> eq=1 at start+33 (also with EARLY_EXIT_EN). Then a=0x8000_0000, b=0x7FFF_FFFF under EARLY_EXIT_EN -> gt=1 at start+2.
- Handshake:
  - start pulsed while busy with different operands -> ignored, original result reported.
  - start held high through the DONE cycle -> second operation begins with no IDLE cycle.
  - Results held while start is low.
- Reset: assert rst at start+10 -> busy, done, lt, eq, gt all 0 immediately; no done pulse afterwards. A new start completes normally.
- Parametric: WIDTH=4, signed, a=4'b1000 (-8), b=4'b0111 (7) -> lt=1 at start+5.
